// File: rtl/ctrl_pipe.sv
// Opcode decode and control-word pipeline (EX/MEM/WB) for the 4-stage core,
// with load-use interlock, jump squash, external freeze and saturating perf counters.
module ctrl_pipe #(
  parameter int OPC_W = 6,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [OPC_W-1:0] id_opcode,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_dst,
  input  logic             ext_stall,
  output logic             id_stall,
  output logic             redirect,
  output logic             ex_valid,
  output logic [10:0]      ex_ctrl,
  output logic             mem_valid,
  output logic [10:0]      mem_ctrl,
  output logic             wb_valid,
  output logic [10:0]      wb_ctrl,
  output logic [RA_W-1:0]  wb_dst,
  output logic             illegal_op,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  localparam logic [OPC_W-1:0] OPC_ADD  = OPC_W'(6'h0a);
  localparam logic [OPC_W-1:0] OPC_SUB  = OPC_W'(6'h0b);
  localparam logic [OPC_W-1:0] OPC_ADDI = OPC_W'(6'h14);
  localparam logic [OPC_W-1:0] OPC_SUBI = OPC_W'(6'h15);
  localparam logic [OPC_W-1:0] OPC_JMPI = OPC_W'(6'h1d);
  localparam logic [OPC_W-1:0] OPC_JMPR = OPC_W'(6'h1e);
  localparam logic [OPC_W-1:0] OPC_LD   = OPC_W'(6'h23);
  localparam logic [OPC_W-1:0] OPC_ST   = OPC_W'(6'h24);

  // Word layout {mux2,mux3,aluop[1:0],mux4,mux5,memR,memW,mux1,RegW,mux6}
  localparam logic [10:0] CTRL_ADD  = 11'b00_0100_000_10;
  localparam logic [10:0] CTRL_SUB  = 11'b00_1000_000_10;
  localparam logic [10:0] CTRL_ADDI = 11'b00_0101_000_10;
  localparam logic [10:0] CTRL_SUBI = 11'b00_1001_000_10;
  localparam logic [10:0] CTRL_JMPI = 11'b01_1100_001_00;
  localparam logic [10:0] CTRL_JMPR = 11'b10_1110_001_00;
  localparam logic [10:0] CTRL_LD   = 11'b10_0101_100_11;
  localparam logic [10:0] CTRL_ST   = 11'b10_0101_010_00;

  localparam int MEMR_B = 4;
  localparam int MUX1_B = 2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [10:0]      w_dec_ctrl;
  logic             w_dec_illegal;
  logic             w_use_rs;
  logic             w_use_rt;
  logic             w_src_hit;
  logic             w_haz;
  logic             w_jmp;

  logic             r_vld_p1, r_vld_p2, r_vld_p3;
  logic [10:0]      r_ctrl_p1, r_ctrl_p2, r_ctrl_p3;
  logic [RA_W-1:0]  r_dst_p1, r_dst_p2, r_dst_p3;
  logic             r_illegal;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_squash_cnt;

  // ID: decode and source-operand usage
  always_comb begin
    w_dec_ctrl    = '0;
    w_dec_illegal = 1'b0;
    w_use_rs      = 1'b1;
    w_use_rt      = 1'b0;
    case (id_opcode)
      OPC_ADD:  begin w_dec_ctrl = CTRL_ADD;  w_use_rt = 1'b1; end
      OPC_SUB:  begin w_dec_ctrl = CTRL_SUB;  w_use_rt = 1'b1; end
      OPC_ADDI: w_dec_ctrl = CTRL_ADDI;
      OPC_SUBI: w_dec_ctrl = CTRL_SUBI;
      OPC_JMPI: begin w_dec_ctrl = CTRL_JMPI; w_use_rs = 1'b0; end
      OPC_JMPR: w_dec_ctrl = CTRL_JMPR;
      OPC_LD:   w_dec_ctrl = CTRL_LD;
      OPC_ST:   begin w_dec_ctrl = CTRL_ST;   w_use_rt = 1'b1; end
      default:  w_dec_illegal = 1'b1;
    endcase
  end

  // A load in EX writing r0 never creates a dependency.
  always_comb begin
    w_src_hit = (w_use_rs && (r_dst_p1 == id_rs)) || (w_use_rt && (r_dst_p1 == id_rt));
    w_haz     = id_valid && r_vld_p1 && r_ctrl_p1[MEMR_B] && (r_dst_p1 != '0) && w_src_hit;
    w_jmp     = r_vld_p1 && r_ctrl_p1[MUX1_B];
  end

  assign redirect = w_jmp && !ext_stall;
  assign id_stall = (w_haz && !w_jmp) || ext_stall;

  // ID -> EX -> MEM -> WB stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_ctrl_p1 <= '0;
      r_dst_p1  <= '0;
      r_vld_p2  <= 1'b0;
      r_ctrl_p2 <= '0;
      r_dst_p2  <= '0;
      r_vld_p3  <= 1'b0;
      r_ctrl_p3 <= '0;
      r_dst_p3  <= '0;
    end else if (!ext_stall) begin
      r_vld_p3  <= r_vld_p2;
      r_ctrl_p3 <= r_ctrl_p2;
      r_dst_p3  <= r_dst_p2;
      r_vld_p2  <= r_vld_p1;
      r_ctrl_p2 <= r_ctrl_p1;
      r_dst_p2  <= r_dst_p1;
      if (w_jmp || w_haz) begin
        r_vld_p1  <= 1'b0;
        r_ctrl_p1 <= '0;
        r_dst_p1  <= '0;
      end else begin
        r_vld_p1  <= id_valid;
        r_ctrl_p1 <= id_valid ? w_dec_ctrl : '0;
        r_dst_p1  <= id_dst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal    <= 1'b0;
      r_stall_cnt  <= '0;
      r_squash_cnt <= '0;
    end else if (ext_stall) begin
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= id_valid && w_dec_illegal && !w_jmp && !w_haz;
      if (w_jmp && id_valid)
        r_squash_cnt <= sat_inc(r_squash_cnt);
      if (w_haz && !w_jmp)
        r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign ex_valid   = r_vld_p1;
  assign ex_ctrl    = r_ctrl_p1;
  assign mem_valid  = r_vld_p2;
  assign mem_ctrl   = r_ctrl_p2;
  assign wb_valid   = r_vld_p3;
  assign wb_ctrl    = r_ctrl_p3;
  assign wb_dst     = r_dst_p3;
  assign illegal_op = r_illegal;
  assign stall_cnt  = r_stall_cnt;
  assign squash_cnt = r_squash_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed scenarios plus randomized traffic checked every
// cycle against a stage-array reference model; a CNT_W=2 copy exercises saturation.
module tb_ctrl_pipe;

  localparam int OPC_W = 6;
  localparam int RA_W  = 5;
  localparam int CNT_W = 16;
  localparam int CNT2_W = 2;

  localparam logic [10:0] C_ADD  = 11'b00_0100_000_10;
  localparam logic [10:0] C_LD   = 11'b10_0101_100_11;
  localparam logic [10:0] C_ST   = 11'b10_0101_010_00;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [OPC_W-1:0] id_opcode;
  logic [RA_W-1:0]  id_rs, id_rt, id_dst;
  logic             ext_stall;

  logic             id_stall, redirect, ex_valid, mem_valid, wb_valid, illegal_op;
  logic [10:0]      ex_ctrl, mem_ctrl, wb_ctrl;
  logic [RA_W-1:0]  wb_dst;
  logic [CNT_W-1:0] stall_cnt, squash_cnt;

  logic              d2_id_stall, d2_redirect, d2_ex_valid, d2_mem_valid, d2_wb_valid, d2_illegal_op;
  logic [10:0]       d2_ex_ctrl, d2_mem_ctrl, d2_wb_ctrl;
  logic [RA_W-1:0]   d2_wb_dst;
  logic [CNT2_W-1:0] d2_stall_cnt, d2_squash_cnt;

  ctrl_pipe #(.OPC_W(OPC_W), .RA_W(RA_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst), .ext_stall(ext_stall),
    .id_stall(id_stall), .redirect(redirect),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .mem_valid(mem_valid), .mem_ctrl(mem_ctrl),
    .wb_valid(wb_valid), .wb_ctrl(wb_ctrl), .wb_dst(wb_dst),
    .illegal_op(illegal_op), .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
  );

  ctrl_pipe #(.OPC_W(OPC_W), .RA_W(RA_W), .CNT_W(CNT2_W)) u_dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst), .ext_stall(ext_stall),
    .id_stall(d2_id_stall), .redirect(d2_redirect),
    .ex_valid(d2_ex_valid), .ex_ctrl(d2_ex_ctrl), .mem_valid(d2_mem_valid), .mem_ctrl(d2_mem_ctrl),
    .wb_valid(d2_wb_valid), .wb_ctrl(d2_wb_ctrl), .wb_dst(d2_wb_dst),
    .illegal_op(d2_illegal_op), .stall_cnt(d2_stall_cnt), .squash_cnt(d2_squash_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one entry per stage (1=EX, 2=MEM, 3=WB), raw event counts.
  typedef struct packed {
    logic            v;
    logic [10:0]     c;
    logic [RA_W-1:0] d;
  } stage_t;

  stage_t m_stg [1:3];
  bit     m_ill;
  int     m_stalls;
  int     m_squashes;
  bit     m_hold;

  function automatic void ref_dec(input logic [OPC_W-1:0] op, output logic [10:0] c,
                                  output bit ill, output bit urs, output bit urt);
    c = '0; ill = 1'b0; urt = 1'b0;
    urs = (op != 6'h1d);
    case (op)
      6'h0a: begin c = 11'b00_0100_000_10; urt = 1'b1; end
      6'h0b: begin c = 11'b00_1000_000_10; urt = 1'b1; end
      6'h14: c = 11'b00_0101_000_10;
      6'h15: c = 11'b00_1001_000_10;
      6'h1d: c = 11'b01_1100_001_00;
      6'h1e: c = 11'b10_1110_001_00;
      6'h23: c = 11'b10_0101_100_11;
      6'h24: begin c = 11'b10_0101_010_00; urt = 1'b1; end
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic bit ref_haz();
    logic [10:0] c;
    bit ill, urs, urt;
    ref_dec(id_opcode, c, ill, urs, urt);
    return id_valid && m_stg[1].v && m_stg[1].c[4] && (m_stg[1].d != 0) &&
           ((urs && m_stg[1].d == id_rs) || (urt && m_stg[1].d == id_rt));
  endfunction

  function automatic bit ref_jmp();
    return m_stg[1].v && m_stg[1].c[2];
  endfunction

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic void model_clear();
    for (int s = 1; s <= 3; s++) m_stg[s] = '0;
    m_ill = 1'b0;
    m_stalls = 0;
    m_squashes = 0;
    m_hold = 1'b0;
  endfunction

  function automatic void model_update();
    logic [10:0] c;
    bit ill, urs, urt, h, j;
    h = ref_haz();
    j = ref_jmp();
    ref_dec(id_opcode, c, ill, urs, urt);
    m_hold = !rst && ((h && !j) || ext_stall);
    if (rst) begin
      model_clear();
    end else if (ext_stall) begin
      m_ill = 1'b0;
    end else begin
      for (int s = 3; s >= 2; s--) m_stg[s] = m_stg[s-1];
      if (j || h) m_stg[1] = '0;
      else        m_stg[1] = {id_valid, (id_valid ? c : 11'd0), id_dst};
      if (j && id_valid) m_squashes++;
      if (h && !j)       m_stalls++;
      m_ill = id_valid && ill && !j && !h;
    end
  endfunction

  task automatic check_all();
    bit h, j;
    h = ref_haz();
    j = ref_jmp();
    check("redirect",   32'(redirect),   32'(j && !ext_stall));
    check("id_stall",   32'(id_stall),   32'((h && !j) || ext_stall));
    check("ex_valid",   32'(ex_valid),   32'(m_stg[1].v));
    check("ex_ctrl",    32'(ex_ctrl),    32'(m_stg[1].c));
    check("mem_valid",  32'(mem_valid),  32'(m_stg[2].v));
    check("mem_ctrl",   32'(mem_ctrl),   32'(m_stg[2].c));
    check("wb_valid",   32'(wb_valid),   32'(m_stg[3].v));
    check("wb_ctrl",    32'(wb_ctrl),    32'(m_stg[3].c));
    check("wb_dst",     32'(wb_dst),     32'(m_stg[3].d));
    check("illegal_op", 32'(illegal_op), 32'(m_ill));
    check("stall_cnt",  32'(stall_cnt),  32'(sat(m_stalls, CNT_W)));
    check("squash_cnt", 32'(squash_cnt), 32'(sat(m_squashes, CNT_W)));
    check("stall_cnt2", 32'(d2_stall_cnt),  32'(sat(m_stalls, CNT2_W)));
    check("squash_cnt2",32'(d2_squash_cnt), 32'(sat(m_squashes, CNT2_W)));
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input logic [5:0] op, input int rs, input int rt, input int dst);
    id_valid  = v;
    id_opcode = op;
    id_rs     = RA_W'(rs);
    id_rt     = RA_W'(rt);
    id_dst    = RA_W'(dst);
    ext_stall = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic do_reset();
    set_id(1'b0, 6'h00, 0, 0, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic rand_instr();
    int k;
    logic [5:0] ops [8];
    ops = '{6'h0a, 6'h0b, 6'h14, 6'h15, 6'h1d, 6'h1e, 6'h23, 6'h24};
    k = $urandom_range(0, 9);
    id_valid  = ($urandom_range(0, 9) != 0);
    id_opcode = (k < 8) ? ops[k] : 6'($urandom_range(0, 63));
    id_rs     = RA_W'($urandom_range(0, 3));
    id_rt     = RA_W'($urandom_range(0, 3));
    id_dst    = RA_W'($urandom_range(0, 3));
  endtask

  initial begin
    set_id(1'b0, 6'h00, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_redirect", 32'(redirect), 32'd0);
    check_all();

    // add flows through with 1/3-cycle latency
    set_id(1'b1, 6'h0a, 1, 2, 7);
    cycle();
    check("add_ex_ctrl", 32'(ex_ctrl), 32'(C_ADD));
    set_id(1'b0, 6'h00, 0, 0, 0);
    cycle();
    cycle();
    check("add_wb_valid", 32'(wb_valid), 32'd1);
    check("add_wb_dst", 32'(wb_dst), 32'd7);

    // load-use stall
    set_id(1'b1, 6'h23, 1, 0, 3);
    cycle();
    set_id(1'b1, 6'h0a, 3, 2, 4);
    #1;
    check("lu_id_stall", 32'(id_stall), 32'd1);
    cycle();
    check("lu_bubble", 32'(ex_valid), 32'd0);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    #1;
    check("lu_released", 32'(id_stall), 32'd0);
    cycle();
    check("lu_add_ex", 32'(ex_ctrl), 32'(C_ADD));

    // ld to r0 and addi with unused rt never stall
    set_id(1'b1, 6'h23, 1, 0, 0);
    cycle();
    set_id(1'b1, 6'h0a, 0, 0, 5);
    #1;
    check("r0_no_stall", 32'(id_stall), 32'd0);
    cycle();
    set_id(1'b1, 6'h23, 1, 0, 6);
    cycle();
    set_id(1'b1, 6'h14, 1, 6, 2);
    #1;
    check("addi_no_stall", 32'(id_stall), 32'd0);
    cycle();

    // jump squashes the following instruction
    do_reset();
    set_id(1'b1, 6'h1d, 0, 0, 0);
    cycle();
    set_id(1'b1, 6'h0b, 1, 2, 3);
    #1;
    check("jmp_redirect", 32'(redirect), 32'd1);
    check("jmp_no_stall", 32'(id_stall), 32'd0);
    cycle();
    check("jmp_squash_cnt", 32'(squash_cnt), 32'd1);
    check("jmp_bubble", 32'(ex_valid), 32'd0);
    set_id(1'b0, 6'h00, 0, 0, 0);
    #1;
    check("jmp_redirect_gone", 32'(redirect), 32'd0);
    cycle();
    check("jmp_sub_not_mem", 32'(mem_valid), 32'd0);

    // external freeze with ld/st/add in flight
    set_id(1'b1, 6'h23, 1, 0, 5); cycle();
    set_id(1'b1, 6'h24, 1, 2, 0); cycle();
    set_id(1'b1, 6'h0a, 1, 2, 4); cycle();
    set_id(1'b1, 6'h0b, 1, 2, 3);
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("frz_ex", 32'(ex_ctrl), 32'(C_ADD));
      check("frz_mem", 32'(mem_ctrl), 32'(C_ST));
      check("frz_wb", 32'(wb_ctrl), 32'(C_LD));
    end
    set_id(1'b0, 6'h00, 0, 0, 0);
    cycle();
    check("frz_resume_wb", 32'(wb_ctrl), 32'(C_ST));

    // illegal opcode
    set_id(1'b1, 6'h3f, 1, 1, 1);
    cycle();
    check("ill_ex_valid", 32'(ex_valid), 32'd1);
    check("ill_ex_ctrl", 32'(ex_ctrl), 32'd0);
    check("ill_pulse", 32'(illegal_op), 32'd1);
    set_id(1'b0, 6'h00, 0, 0, 0);
    cycle();
    check("ill_pulse_end", 32'(illegal_op), 32'd0);

    // five load-use stalls: narrow counter saturates at 3
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_id(1'b1, 6'h23, 1, 0, 3); cycle();
      set_id(1'b1, 6'h0a, 3, 2, 4); cycle();
      cycle();
    end
    check("sat_cnt16", 32'(stall_cnt), 32'd5);
    check("sat_cnt2", 32'(d2_stall_cnt), 32'd3);

    // reset in the middle of a stall
    set_id(1'b1, 6'h23, 1, 0, 3); cycle();
    set_id(1'b1, 6'h0a, 3, 2, 4);
    rst = 1'b1;
    cycle();
    set_id(1'b0, 6'h00, 0, 0, 0);
    #1;
    check("rst_mid_ex", 32'(ex_valid), 32'd0);
    check("rst_mid_cnt", 32'(stall_cnt), 32'd0);
    check("rst_mid_stall", 32'(id_stall), 32'd0);

    // reset while a jump sits in EX: no redirect afterwards
    set_id(1'b1, 6'h1e, 1, 0, 0); cycle();
    set_id(1'b1, 6'h0a, 1, 2, 3);
    rst = 1'b1;
    cycle();
    set_id(1'b0, 6'h00, 0, 0, 0);
    #1;
    check("rst_jmp_redirect", 32'(redirect), 32'd0);
    cycle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (!m_hold) rand_instr();
      ext_stall = ($urandom_range(0, 99) < 12);
      rst       = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
